// File: rtl/stk_pkg.sv
// Shared sizing and state types for the stk pipeline memory controller.
package stk_pkg;

    localparam int BANKS_N = 2;
    localparam int LINES_N = 8;
    localparam int LINE_W  = $clog2(LINES_N);

    typedef logic [LINE_W-1:0] line_id_t;

    typedef enum logic [1:0] {
        INIT,
        RDY,
        DRAIN
    } stk_mem_ctrl_st_t;

    // What an SRAM port writes into each line during initialisation.
    typedef enum logic {
        DIN_ZERO,
        DIN_LINK
    } init_din_t;

endpackage

// File: rtl/stk_pipe_mem_ctrl_port.sv
// One SRAM port group (all banks): init/pipe mux, registered SRAM drive,
// and the read-valid shift register aligned to SRAM dout.
module stk_pipe_mem_ctrl_port
    import stk_pkg::*;
#(
    parameter int        BANKS_N  = 2,
    parameter int        LINE_W   = 3,
    parameter int        DIN_W    = 3,
    parameter init_din_t INIT_DIN = DIN_ZERO
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            init_i,
    input  logic                            pipe_en_i,
    input  logic [LINE_W-1:0]               init_line_i,
    input  logic [LINE_W-1:0]               init_link_i,
    input  logic [BANKS_N-1:0]              pipe_ce_i,
    input  logic [BANKS_N-1:0]              pipe_oe_i,
    input  logic [BANKS_N-1:0][LINE_W-1:0]  pipe_addr_i,
    input  logic [BANKS_N-1:0][DIN_W-1:0]   pipe_din_i,
    output logic [BANKS_N-1:0]              mem_ce_o,
    output logic [BANKS_N-1:0]              mem_oe_o,
    output logic [BANKS_N-1:0][LINE_W-1:0]  mem_addr_o,
    output logic [BANKS_N-1:0][DIN_W-1:0]   mem_din_o,
    output logic [BANKS_N-1:0]              vld_o
);

    logic [BANKS_N-1:0]             ce_d, ce_q;
    logic [BANKS_N-1:0]             oe_d, oe_q;
    logic [BANKS_N-1:0][LINE_W-1:0] addr_d, addr_q;
    logic [BANKS_N-1:0][DIN_W-1:0]  din_d, din_q;
    logic [BANKS_N-1:0]             rd_q, vld_q;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through it can leave a value unassigned and infer a latch.
    always_comb begin
        ce_d   = pipe_en_i ? pipe_ce_i : '0;
        oe_d   = pipe_oe_i;
        addr_d = pipe_addr_i;
        din_d  = pipe_din_i;
        if (init_i) begin
            ce_d = '1;
            oe_d = '0;
            for (int b = 0; b < BANKS_N; b++) begin
                addr_d[b] = init_line_i;
                din_d[b]  = (INIT_DIN == DIN_LINK) ? DIN_W'(init_link_i) : '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_q   <= '0;
            oe_q   <= '0;
            addr_q <= '0;
            din_q  <= '0;
            rd_q   <= '0;
            vld_q  <= '0;
        end else begin
            ce_q   <= ce_d;
            oe_q   <= oe_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            rd_q   <= ce_d & oe_d;
            vld_q  <= rd_q;
        end
    end

    assign mem_ce_o   = ce_q;
    assign mem_oe_o   = oe_q;
    assign mem_addr_o = addr_q;
    assign mem_din_o  = din_q;
    assign vld_o      = vld_q;

endmodule

// File: rtl/stk_pipe_mem_ctrl.sv
// Stack memory controller: initialises head/tail/data SRAMs after reset and
// on flush, then hands the SRAM ports to the pipeline through one register.
module stk_pipe_mem_ctrl
    import stk_pkg::*;
#(
    parameter int  BANKS_N = stk_pkg::BANKS_N,
    parameter int  LINES_N = stk_pkg::LINES_N,
    parameter int  DAT_W   = 128,
    localparam int LINE_W  = $clog2(LINES_N)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_flush_req,
    output logic                            o_flush_ack,
    output logic                            o_rdy,
    input  logic [BANKS_N-1:0]              i_pipe_head_ce,
    input  logic [BANKS_N-1:0]              i_pipe_head_oe,
    input  logic [BANKS_N-1:0][LINE_W-1:0]  i_pipe_head_addr,
    input  logic [BANKS_N-1:0][LINE_W-1:0]  i_pipe_head_din,
    input  logic [BANKS_N-1:0]              i_pipe_tail_ce,
    input  logic [BANKS_N-1:0]              i_pipe_tail_oe,
    input  logic [BANKS_N-1:0][LINE_W-1:0]  i_pipe_tail_addr,
    input  logic [BANKS_N-1:0][LINE_W-1:0]  i_pipe_tail_din,
    input  logic [BANKS_N-1:0]              i_pipe_dat_ce,
    input  logic [BANKS_N-1:0]              i_pipe_dat_oe,
    input  logic [BANKS_N-1:0][LINE_W-1:0]  i_pipe_dat_addr,
    input  logic [BANKS_N-1:0][DAT_W-1:0]   i_pipe_dat_din,
    output logic [BANKS_N-1:0]              o_mem_head_ce,
    output logic [BANKS_N-1:0]              o_mem_head_oe,
    output logic [BANKS_N-1:0][LINE_W-1:0]  o_mem_head_addr,
    output logic [BANKS_N-1:0][LINE_W-1:0]  o_mem_head_din,
    output logic [BANKS_N-1:0]              o_mem_tail_ce,
    output logic [BANKS_N-1:0]              o_mem_tail_oe,
    output logic [BANKS_N-1:0][LINE_W-1:0]  o_mem_tail_addr,
    output logic [BANKS_N-1:0][LINE_W-1:0]  o_mem_tail_din,
    output logic [BANKS_N-1:0]              o_mem_dat_ce,
    output logic [BANKS_N-1:0]              o_mem_dat_oe,
    output logic [BANKS_N-1:0][LINE_W-1:0]  o_mem_dat_addr,
    output logic [BANKS_N-1:0][DAT_W-1:0]   o_mem_dat_din,
    output logic [BANKS_N-1:0]              o_pipe_head_vld,
    output logic [BANKS_N-1:0]              o_pipe_tail_vld,
    output logic [BANKS_N-1:0]              o_pipe_dat_vld
);

    stk_mem_ctrl_st_t  state_d, state_q;
    logic [LINE_W-1:0] cnt_d, cnt_q;
    logic [LINE_W-1:0] link;
    logic              flush_pend_d, flush_pend_q;
    logic              flush_req_q;
    logic              rdy_d, rdy_q;
    logic              ack_d, ack_q;
    logic              flush_take;
    logic              init_mode;
    logic              pipe_en;

    // A flush is taken only on a request edge seen while the pipe owns the SRAMs.
    assign flush_take = rdy_q & i_flush_req & ~flush_req_q;
    assign link       = cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            flush_req_q  <= 1'b0;
            rdy_q        <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            flush_req_q  <= i_flush_req;
            rdy_q        <= rdy_d;
            ack_q        <= ack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        rdy_d        = 1'b0;
        ack_d        = 1'b0;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LINE_W'(LINES_N - 1)) begin
                    state_d = RDY;
                    cnt_d   = '0;
                end
            end
            RDY: begin
                if (flush_take) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    rdy_d = 1'b1;
                    // First cycle of ownership closes out a flush-triggered init.
                    if (!rdy_q && flush_pend_q) begin
                        ack_d        = 1'b1;
                        flush_pend_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LINE_W'(1)) begin
                    state_d      = INIT;
                    cnt_d        = '0;
                    flush_pend_d = 1'b1;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        init_mode = (state_q == INIT);
        pipe_en   = rdy_q;
    end

    assign o_rdy       = rdy_q;
    assign o_flush_ack = ack_q;

    stk_pipe_mem_ctrl_port #(
        .BANKS_N(BANKS_N), .LINE_W(LINE_W), .DIN_W(LINE_W), .INIT_DIN(DIN_ZERO)
    ) u_head (
        .clk(clk), .rst(rst), .init_i(init_mode), .pipe_en_i(pipe_en),
        .init_line_i(cnt_q), .init_link_i(link),
        .pipe_ce_i(i_pipe_head_ce), .pipe_oe_i(i_pipe_head_oe),
        .pipe_addr_i(i_pipe_head_addr), .pipe_din_i(i_pipe_head_din),
        .mem_ce_o(o_mem_head_ce), .mem_oe_o(o_mem_head_oe),
        .mem_addr_o(o_mem_head_addr), .mem_din_o(o_mem_head_din),
        .vld_o(o_pipe_head_vld)
    );

    stk_pipe_mem_ctrl_port #(
        .BANKS_N(BANKS_N), .LINE_W(LINE_W), .DIN_W(LINE_W), .INIT_DIN(DIN_LINK)
    ) u_tail (
        .clk(clk), .rst(rst), .init_i(init_mode), .pipe_en_i(pipe_en),
        .init_line_i(cnt_q), .init_link_i(link),
        .pipe_ce_i(i_pipe_tail_ce), .pipe_oe_i(i_pipe_tail_oe),
        .pipe_addr_i(i_pipe_tail_addr), .pipe_din_i(i_pipe_tail_din),
        .mem_ce_o(o_mem_tail_ce), .mem_oe_o(o_mem_tail_oe),
        .mem_addr_o(o_mem_tail_addr), .mem_din_o(o_mem_tail_din),
        .vld_o(o_pipe_tail_vld)
    );

    stk_pipe_mem_ctrl_port #(
        .BANKS_N(BANKS_N), .LINE_W(LINE_W), .DIN_W(DAT_W), .INIT_DIN(DIN_ZERO)
    ) u_dat (
        .clk(clk), .rst(rst), .init_i(init_mode), .pipe_en_i(pipe_en),
        .init_line_i(cnt_q), .init_link_i(link),
        .pipe_ce_i(i_pipe_dat_ce), .pipe_oe_i(i_pipe_dat_oe),
        .pipe_addr_i(i_pipe_dat_addr), .pipe_din_i(i_pipe_dat_din),
        .mem_ce_o(o_mem_dat_ce), .mem_oe_o(o_mem_dat_oe),
        .mem_addr_o(o_mem_dat_addr), .mem_din_o(o_mem_dat_din),
        .vld_o(o_pipe_dat_vld)
    );

endmodule

// File: tb/tb_stk_pipe_mem_ctrl.sv
// Directed bench for stk_pipe_mem_ctrl with BANKS_N=2, LINES_N=8, DAT_W=128.
module tb_stk_pipe_mem_ctrl;

    localparam int B  = 2;
    localparam int L  = 8;
    localparam int LW = 3;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst;
    logic i_flush_req;
    logic o_flush_ack, o_rdy;
    logic [B-1:0]         i_pipe_head_ce, i_pipe_head_oe, i_pipe_tail_ce, i_pipe_tail_oe;
    logic [B-1:0]         i_pipe_dat_ce, i_pipe_dat_oe;
    logic [B-1:0][LW-1:0] i_pipe_head_addr, i_pipe_head_din, i_pipe_tail_addr, i_pipe_tail_din;
    logic [B-1:0][LW-1:0] i_pipe_dat_addr;
    logic [B-1:0][DW-1:0] i_pipe_dat_din;
    logic [B-1:0]         o_mem_head_ce, o_mem_head_oe, o_mem_tail_ce, o_mem_tail_oe;
    logic [B-1:0]         o_mem_dat_ce, o_mem_dat_oe;
    logic [B-1:0][LW-1:0] o_mem_head_addr, o_mem_head_din, o_mem_tail_addr, o_mem_tail_din;
    logic [B-1:0][LW-1:0] o_mem_dat_addr;
    logic [B-1:0][DW-1:0] o_mem_dat_din;
    logic [B-1:0]         o_pipe_head_vld, o_pipe_tail_vld, o_pipe_dat_vld;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    stk_pipe_mem_ctrl #(.BANKS_N(B), .LINES_N(L), .DAT_W(DW)) dut (
        .clk(clk), .rst(rst), .i_flush_req(i_flush_req),
        .o_flush_ack(o_flush_ack), .o_rdy(o_rdy),
        .i_pipe_head_ce(i_pipe_head_ce), .i_pipe_head_oe(i_pipe_head_oe),
        .i_pipe_head_addr(i_pipe_head_addr), .i_pipe_head_din(i_pipe_head_din),
        .i_pipe_tail_ce(i_pipe_tail_ce), .i_pipe_tail_oe(i_pipe_tail_oe),
        .i_pipe_tail_addr(i_pipe_tail_addr), .i_pipe_tail_din(i_pipe_tail_din),
        .i_pipe_dat_ce(i_pipe_dat_ce), .i_pipe_dat_oe(i_pipe_dat_oe),
        .i_pipe_dat_addr(i_pipe_dat_addr), .i_pipe_dat_din(i_pipe_dat_din),
        .o_mem_head_ce(o_mem_head_ce), .o_mem_head_oe(o_mem_head_oe),
        .o_mem_head_addr(o_mem_head_addr), .o_mem_head_din(o_mem_head_din),
        .o_mem_tail_ce(o_mem_tail_ce), .o_mem_tail_oe(o_mem_tail_oe),
        .o_mem_tail_addr(o_mem_tail_addr), .o_mem_tail_din(o_mem_tail_din),
        .o_mem_dat_ce(o_mem_dat_ce), .o_mem_dat_oe(o_mem_dat_oe),
        .o_mem_dat_addr(o_mem_dat_addr), .o_mem_dat_din(o_mem_dat_din),
        .o_pipe_head_vld(o_pipe_head_vld), .o_pipe_tail_vld(o_pipe_tail_vld),
        .o_pipe_dat_vld(o_pipe_dat_vld)
    );

    // Pipe ce while the controller does not own the SRAMs is a protocol error.
    a_no_ce_when_busy: assert property (@(posedge clk) disable iff (rst)
        !o_rdy |-> !(|{i_pipe_head_ce, i_pipe_tail_ce, i_pipe_dat_ce}))
        else $error("protocol error: pipe ce while o_rdy=0");

    typedef struct {
        int           port;      // 0 head, 1 tail, 2 dat
        int           bank;
        logic         oe;
        logic [2:0]   addr;
        logic [127:0] din;
        logic [5:0]   exp_ce;    // {head, tail, dat} x 2 banks
        logic [5:0]   exp_oe;
        logic [2:0]   exp_addr;
        logic [127:0] exp_din;
        logic [5:0]   exp_vld;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(int port, int bank, logic oe, logic [2:0] addr,
                                logic [127:0] din, logic [5:0] ce, logic [5:0] oev,
                                logic [2:0] ea, logic [127:0] ed, logic [5:0] vld);
        vec_t v;
        v.port = port; v.bank = bank; v.oe = oe; v.addr = addr; v.din = din;
        v.exp_ce = ce; v.exp_oe = oev; v.exp_addr = ea; v.exp_din = ed; v.exp_vld = vld;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        i_pipe_head_ce = '0; i_pipe_head_oe = '0; i_pipe_head_addr = '0; i_pipe_head_din = '0;
        i_pipe_tail_ce = '0; i_pipe_tail_oe = '0; i_pipe_tail_addr = '0; i_pipe_tail_din = '0;
        i_pipe_dat_ce  = '0; i_pipe_dat_oe  = '0; i_pipe_dat_addr  = '0; i_pipe_dat_din  = '0;
    endtask

    task automatic drive_vec(input vec_t v);
        drive_idle();
        case (v.port)
            0: begin
                i_pipe_head_ce[v.bank] = 1'b1; i_pipe_head_oe[v.bank] = v.oe;
                i_pipe_head_addr[v.bank] = v.addr; i_pipe_head_din[v.bank] = v.din[2:0];
            end
            1: begin
                i_pipe_tail_ce[v.bank] = 1'b1; i_pipe_tail_oe[v.bank] = v.oe;
                i_pipe_tail_addr[v.bank] = v.addr; i_pipe_tail_din[v.bank] = v.din[2:0];
            end
            default: begin
                i_pipe_dat_ce[v.bank] = 1'b1; i_pipe_dat_oe[v.bank] = v.oe;
                i_pipe_dat_addr[v.bank] = v.addr; i_pipe_dat_din[v.bank] = v.din;
            end
        endcase
    endtask

    function automatic logic [2:0] mem_addr(int port, int bank);
        case (port)
            0:       return o_mem_head_addr[bank];
            1:       return o_mem_tail_addr[bank];
            default: return o_mem_dat_addr[bank];
        endcase
    endfunction

    function automatic logic [127:0] mem_din(int port, int bank);
        case (port)
            0:       return {125'd0, o_mem_head_din[bank]};
            1:       return {125'd0, o_mem_tail_din[bank]};
            default: return o_mem_dat_din[bank];
        endcase
    endfunction

    function automatic logic [5:0] all_ce();
        return {o_mem_head_ce, o_mem_tail_ce, o_mem_dat_ce};
    endfunction

    function automatic logic [5:0] all_vld();
        return {o_pipe_head_vld, o_pipe_tail_vld, o_pipe_dat_vld};
    endfunction

    function automatic logic [17:0] all_addr();
        return {o_mem_head_addr, o_mem_tail_addr, o_mem_dat_addr};
    endfunction

    // Steps until o_rdy rises (bounded); counts acks along the way.
    task automatic wait_ready(output int cyc, output int acks, output logic ack_at_rdy);
        cyc = 0; acks = 0; ack_at_rdy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            cyc++;
            if (o_flush_ack) acks++;
            if (o_rdy) begin
                ack_at_rdy = o_flush_ack;
                break;
            end
        end
    endtask

    task automatic count_acks(input int n, output int acks);
        acks = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (o_flush_ack) acks++;
        end
    endtask

    initial begin
        int        cyc, acks, extra, busy;
        logic      ack_at_rdy;
        logic [2:0] ln, lk;

        vecs[0] = mk(0, 1, 1'b1, 3'd5, '0, 6'b10_00_00, 6'b10_00_00, 3'd5, '0, 6'b10_00_00);
        vecs[1] = mk(2, 0, 1'b0, 3'd3, {4{32'hA5A5_A5A5}}, 6'b00_00_01, 6'b00_00_00, 3'd3,
                     {4{32'hA5A5_A5A5}}, 6'b00_00_00);
        vecs[2] = mk(1, 0, 1'b1, 3'd7, '0, 6'b00_01_00, 6'b00_01_00, 3'd7, '0, 6'b00_01_00);
        vecs[3] = mk(1, 1, 1'b0, 3'd2, 128'd6, 6'b00_10_00, 6'b00_00_00, 3'd2, 128'd6, 6'b00_00_00);
        vecs[4] = mk(2, 1, 1'b1, 3'd0, '0, 6'b00_00_10, 6'b00_00_10, 3'd0, '0, 6'b00_00_10);
        vecs[5] = mk(0, 0, 1'b0, 3'd4, 128'd3, 6'b01_00_00, 6'b00_00_00, 3'd4, 128'd3, 6'b00_00_00);
        vecs[6] = mk(0, 0, 1'b1, 3'd6, '0, 6'b01_00_00, 6'b01_00_00, 3'd6, '0, 6'b01_00_00);

        rst = 1'b1;
        i_flush_req = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("rst_ce",   {58'd0, all_ce()}, '0);
        check("rst_oe",   {o_mem_head_oe, o_mem_tail_oe, o_mem_dat_oe}, '0);
        check("rst_addr", {110'd0, all_addr()}, '0);
        check("rst_din",  {o_mem_head_din, o_mem_tail_din, |o_mem_dat_din}, '0);
        check("rst_vld",  {58'd0, all_vld()}, '0);
        check("rst_rdy_ack", {o_rdy, o_flush_ack}, '0);

        // Post-reset init: line k presented in cycle k+1, tail linked to k+1.
        rst = 1'b0;
        for (int j = 1; j <= L; j++) begin
            step();
            ln = 3'(j - 1);
            lk = ln + 3'd1;
            check($sformatf("init%0d_ce", j),   {58'd0, all_ce()}, 128'h3F);
            check($sformatf("init%0d_oe", j),   {o_mem_head_oe, o_mem_tail_oe, o_mem_dat_oe}, '0);
            check($sformatf("init%0d_addr", j), {110'd0, all_addr()}, {110'd0, {6{ln}}});
            check($sformatf("init%0d_tail_din", j), {122'd0, o_mem_tail_din}, {122'd0, lk, lk});
            check($sformatf("init%0d_zero_din", j), {o_mem_head_din, |o_mem_dat_din}, '0);
            check($sformatf("init%0d_rdy_ack", j), {o_rdy, o_flush_ack}, '0);
        end
        step();
        check("post_init_rdy_ack", {o_rdy, o_flush_ack}, 128'b10);
        check("post_init_ce", {58'd0, all_ce()}, '0);

        // Table-driven pipe accesses in RDY.
        for (int i = 0; i < 7; i++) begin
            drive_vec(vecs[i]);
            step();
            drive_idle();
            check($sformatf("v%0d_ce", i), {58'd0, all_ce()}, {58'd0, vecs[i].exp_ce});
            check($sformatf("v%0d_oe", i), {o_mem_head_oe, o_mem_tail_oe, o_mem_dat_oe},
                  {58'd0, vecs[i].exp_oe});
            check($sformatf("v%0d_addr", i), {125'd0, mem_addr(vecs[i].port, vecs[i].bank)},
                  {125'd0, vecs[i].exp_addr});
            check($sformatf("v%0d_din", i), mem_din(vecs[i].port, vecs[i].bank), vecs[i].exp_din);
            check($sformatf("v%0d_vld_early", i), {58'd0, all_vld()}, '0);
            step();
            check($sformatf("v%0d_vld", i), {58'd0, all_vld()}, {58'd0, vecs[i].exp_vld});
            check($sformatf("v%0d_ce_idle", i), {58'd0, all_ce()}, '0);
        end

        // Read in the same cycle as the flush edge: accepted, vld returns in DRAIN.
        drive_idle();
        i_pipe_head_ce[0] = 1'b1; i_pipe_head_oe[0] = 1'b1; i_pipe_head_addr[0] = 3'd2;
        i_flush_req = 1'b1;
        step();
        drive_idle();
        i_flush_req = 1'b0;
        check("fl_read_ce", {58'd0, all_ce()}, 128'b01_00_00);
        check("fl_read_addr", {125'd0, o_mem_head_addr[0]}, 128'd2);
        check("fl_drain1_rdy", {127'd0, o_rdy}, '0);
        step();
        check("fl_read_vld", {58'd0, all_vld()}, 128'b01_00_00);
        check("fl_drain2_ce", {58'd0, all_ce()}, '0);
        step();
        check("fl_drain_end_ce", {58'd0, all_ce()}, '0);
        step();
        check("fl_reinit_line0", {110'd0, all_ce(), all_addr()[11:0]}, {110'd0, 6'h3F, 12'd0});
        wait_ready(cyc, acks, ack_at_rdy);
        check("fl_rdy_latency", cyc, 8);
        check("fl_ack_count", acks, 1);
        check("fl_ack_with_rdy", {127'd0, ack_at_rdy}, 128'd1);
        count_acks(4, extra);
        check("fl_no_extra_ack", extra, 0);

        // Request held high through the whole init: one ack, no re-flush.
        i_flush_req = 1'b1;
        wait_ready(cyc, acks, ack_at_rdy);
        check("hold_rdy_latency", cyc, 12);
        check("hold_ack_count", acks, 1);
        check("hold_ack_with_rdy", {127'd0, ack_at_rdy}, 128'd1);
        busy = 0; extra = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (!o_rdy) busy++;
            if (o_flush_ack) extra++;
        end
        check("hold_stays_rdy", busy, 0);
        check("hold_no_extra_ack", extra, 0);
        i_flush_req = 1'b0;
        step();
        check("hold_drop_rdy", {127'd0, o_rdy}, 128'd1);
        i_flush_req = 1'b1;
        step();
        i_flush_req = 1'b0;
        check("reflush_taken", {127'd0, o_rdy}, '0);
        wait_ready(cyc, acks, ack_at_rdy);
        check("reflush_rdy_latency", cyc, 11);
        check("reflush_ack_count", acks, 1);

        // Reset during the flush init at line 4: outputs clear at once, no ack.
        i_flush_req = 1'b1;
        step();
        i_flush_req = 1'b0;
        repeat (7) step();
        check("abort_pre_line4", {125'd0, o_mem_head_addr[0]}, 128'd4);
        check("abort_pre_tail_din", {125'd0, o_mem_tail_din[1]}, 128'd5);
        #1 rst = 1'b1;
        #1;
        check("abort_ce", {58'd0, all_ce()}, '0);
        check("abort_addr_din", {104'd0, all_addr(), o_mem_tail_din}, '0);
        check("abort_rdy_ack", {o_rdy, o_flush_ack}, '0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("abort_restart_line0", {110'd0, all_ce(), all_addr()[11:0]}, {110'd0, 6'h3F, 12'd0});
        wait_ready(cyc, acks, ack_at_rdy);
        check("abort_rdy_latency", cyc, 8);
        count_acks(4, extra);
        check("abort_no_ack", acks + extra, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
